// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader
//   Operand-assembly stage for the MPU element-wise add/sub units. Collects
//   signed elements one per valid/ready beat: the first DIM*DIM fill matrix A,
//   the next DIM*DIM fill matrix B. The assembled pair is then presented with
//   out_valid and held stable until the arithmetic stage takes it.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   clear                 synchronous abort: drop partial load, zero both matrices
//   in_data/in_valid      element stream input
//   in_ready              high whenever the loader is not holding a finished pair
//   matrix_a, matrix_b    flattened row-major matrices, element i at [i*ELEM_W +: ELEM_W]
//   out_valid/out_ready   operand-pair handshake
//   loading_b             high while matrix B is being filled
//   elem_idx              index of the next element slot to be written
module mpu_matrix_loader #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5,
    parameter int IDX_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [ELEM_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ELEM_W*DIM*DIM-1:0]  matrix_a,
    output logic [ELEM_W*DIM*DIM-1:0]  matrix_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       loading_b,
    output logic [IDX_W-1:0]           elem_idx
);

    localparam int N = DIM * DIM;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic [N-1:0][ELEM_W-1:0] mat_a, mat_b;
    logic                    xfer;
    logic                    last;

    // All status outputs decode straight from registered state, so out_valid
    // rises in the cycle after the edge that accepted the final B element.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign loading_b = (state == LOAD_B);

    assign xfer = in_valid & in_ready;
    assign last = (elem_idx == IDX_W'(N - 1));

    assign matrix_a = mat_a;
    assign matrix_b = mat_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD_A;
            elem_idx <= '0;
        end else begin
            state    <= state_nxt;
            elem_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = elem_idx;
        if (clear) begin
            // Abort wins over any simultaneous input beat or output handshake.
            state_nxt = LOAD_A;
            idx_nxt   = '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        if (last) begin
                            state_nxt = LOAD_B;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = elem_idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        if (last) begin
                            state_nxt = HOLD;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = elem_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state_nxt = LOAD_A;
                end
                default: begin
                    state_nxt = LOAD_A;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Matrices are only touched by an accepted beat (never in HOLD, since
    // in_ready is low there), so they stay stable while out_valid is high.
    // Old contents survive a handshake and are overwritten slot by slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_a <= '0;
            mat_b <= '0;
        end else if (clear) begin
            mat_a <= '0;
            mat_b <= '0;
        end else if (xfer) begin
            if (state == LOAD_A) mat_a[elem_idx] <= in_data;
            else                 mat_b[elem_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
module tb_mpu_matrix_loader;

    localparam int EW = 8;
    localparam int D  = 5;
    localparam int IW = 5;
    localparam int N  = D * D;
    localparam int MW = EW * N;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic [EW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] matrix_a;
    logic [MW-1:0] matrix_b;
    logic          out_valid;
    logic          out_ready;
    logic          loading_b;
    logic [IW-1:0] elem_idx;

    mpu_matrix_loader #(.ELEM_W(EW), .DIM(D), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .loading_b (loading_b),
        .elem_idx  (elem_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
    } pair_t;

    pair_t sb_q[$];
    pair_t popped;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int ov_cycles = 0;

    // Reference model of the load sequence
    logic [MW-1:0] exp_a, exp_b;
    int            m_idx;
    bit            m_b;

    task automatic model_reset();
        exp_a = '0;
        exp_b = '0;
        m_idx = 0;
        m_b   = 0;
    endtask

    task automatic model_accept(input logic [EW-1:0] d, output bit pushed);
        pushed = 0;
        if (!m_b) exp_a[m_idx*EW +: EW] = d;
        else      exp_b[m_idx*EW +: EW] = d;
        if (m_idx == N - 1) begin
            m_idx = 0;
            if (m_b) begin
                sb_q.push_back('{a: exp_a, b: exp_b});
                pushed = 1;
            end
            m_b = !m_b;
        end else begin
            m_idx++;
        end
    endtask

    // Scoreboard: compare the presented pair on every output handshake
    always @(posedge clk) begin
        if (rst_n && out_valid) ov_cycles++;
        if (rst_n && out_valid && out_ready) begin
            hs_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pair: got handshake, expected none queued");
            end else begin
                popped = sb_q.pop_front();
                if (matrix_a !== popped.a || matrix_b !== popped.b) begin
                    errors++;
                    $display("FAIL sb_pair: a=%h b=%h expected a=%h b=%h",
                             matrix_a, matrix_b, popped.a, popped.b);
                end
            end
        end
    end

    // Drive one element; waits (bounded) for in_ready, returns #1 after the accepting edge
    task automatic send(input logic [EW-1:0] d);
        int  t;
        bit  pushed;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
        end else begin
            @(posedge clk);
            #1;
            model_accept(d, pushed);
            if (pushed) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL out_valid_latency: got %b expected 1", out_valid);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #12;
        checks++;
        if (elem_idx !== '0 || out_valid !== 1'b0 || loading_b !== 1'b0 ||
            matrix_a !== '0 || matrix_b !== '0) begin
            errors++;
            $display("FAIL reset_values: idx=%0d ov=%b lb=%b a=%h b=%h expected all 0",
                     elem_idx, out_valid, loading_b, matrix_a, matrix_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 2 * N; i++) begin
            if (i == 2 * N - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_out_valid: got %b expected 0", out_valid);
                end
            end
            send((i < N) ? EW'(i + 1) : EW'(2 * N - i));
            if (i == N - 1) begin
                checks++;
                if (loading_b !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_loading_b: got %b expected 1", loading_b);
                end
            end
        end
        checks++;
        if (matrix_a[7:0] !== 8'd1 || matrix_a[199:192] !== 8'd25 ||
            matrix_b[7:0] !== 8'd25 || matrix_b[199:192] !== 8'd1) begin
            errors++;
            $display("FAIL stream_corners: a0=%0d a24=%0d b0=%0d b24=%0d expected 1 25 25 1",
                     matrix_a[7:0], matrix_a[199:192], matrix_b[7:0], matrix_b[199:192]);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_in_ready: got %b expected 0", in_ready);
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = EW'($urandom);
            @(posedge clk); #1;
            checks++;
            if (matrix_a !== exp_a || matrix_b !== exp_b || elem_idx !== '0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable: cyc=%0d idx=%0d ov=%b a=%h expected a=%h idx 0 ov 1",
                         c, elem_idx, out_valid, matrix_a, exp_a);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: ov=%b ir=%b expected 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake_drop: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_alternate();
        logic [EW-1:0] pat [3];
        int  k;
        bit  pushed;
        pat[0] = 8'h80; pat[1] = 8'h7F; pat[2] = 8'hFF;
        k = 0;
        for (int c = 0; c < 4 * N; c++) begin
            @(negedge clk);
            in_valid = (c % 2 == 0);
            in_data  = pat[k % 3];
            @(posedge clk); #1;
            if (c % 2 == 0) begin
                model_accept(pat[k % 3], pushed);
                k++;
            end
            checks++;
            if (out_valid === 1'b0 && elem_idx !== IW'(m_idx)) begin
                errors++;
                $display("FAIL alt_idx: cyc=%0d got %0d expected %0d", c, elem_idx, m_idx);
            end
            if (k == N && c % 2 == 0) begin
                checks++;
                if (loading_b !== 1'b1) begin
                    errors++;
                    $display("FAIL alt_loading_b: got %b expected 1", loading_b);
                end
            end
        end
        checks++;
        if (matrix_a[7:0] !== 8'h80 || matrix_a[15:8] !== 8'h7F || matrix_a[23:16] !== 8'hFF ||
            matrix_b[7:0] !== 8'h7F || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL alt_bytes: a=%h %h %h b0=%h ov=%b expected 80 7f ff 7f 1",
                     matrix_a[7:0], matrix_a[15:8], matrix_a[23:16], matrix_b[7:0], out_valid);
        end
        handshake();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 30; i++) send(EW'($urandom));
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        checks++;
        if (elem_idx !== '0 || loading_b !== 1'b0 || matrix_a !== '0 ||
            matrix_b !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_values: idx=%0d lb=%b ov=%b a=%h b=%h expected all 0",
                     elem_idx, loading_b, out_valid, matrix_a, matrix_b);
        end
        for (int i = 0; i < 2 * N; i++) send(EW'($urandom));
        handshake();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 30; i++) send(EW'($urandom));
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (elem_idx !== '0 || loading_b !== 1'b0 || matrix_a !== '0 ||
            matrix_b !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: idx=%0d lb=%b ov=%b ir=%b a=%h expected 0 0 0 1 0",
                     elem_idx, loading_b, out_valid, in_ready, matrix_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int ov0, hs0;
        ov0 = ov_cycles;
        hs0 = hs_count;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4 * N; i++) send(EW'($urandom));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ov_cycles - ov0 != 2 || hs_count - hs0 != 2 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_counts: ov_cycles=%0d hs=%0d queued=%0d expected 2 2 0",
                     ov_cycles - ov0, hs_count - hs0, sb_q.size());
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_alternate();
        test_clear();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d pairs never presented, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
